// File: rtl/bp_cce_mem_arbiter.sv
// Shares one memory command/response port between several CCEs: round-robin command
// arbitration, in-order response steering through a source-ID FIFO, and per-CCE credits.
module bp_cce_mem_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  localparam int lg_req_lp        = $clog2(num_req_p),
  localparam int sid_els_lp       = num_req_p * max_outstanding_p
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_yumi_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_ready_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_ready_i
);

  localparam int credit_w_lp = $clog2(max_outstanding_p + 1);
  localparam int ptr_w_lp    = (sid_els_lp > 1) ? $clog2(sid_els_lp) : 1;
  localparam int cnt_w_lp    = $clog2(sid_els_lp + 1);
  localparam int idx_w_lp    = lg_req_lp + 1;

  typedef enum logic {e_idle, e_send} state_e;

  state_e                 state_r, state_n;
  logic [lg_req_lp-1:0]   gnt_r, gnt_n, rr_r, rr_next, pick, head;
  logic [idx_w_lp-1:0]    cand;
  logic [num_req_p-1:0]   eligible, gnt_oh, resp_oh, inc_oh, dec_oh;
  logic [credit_w_lp-1:0] credit [num_req_p];
  logic [msg_width_p-1:0] cmd_slice [num_req_p];
  logic [lg_req_lp-1:0]   sid_mem [sid_els_lp];
  logic [ptr_w_lp-1:0]    rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0]    count;
  logic                   fifo_full, fifo_nonempty, send_fire, resp_fire;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(sid_els_lp - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  for (genvar g = 0; g < num_req_p; g++) begin : g_slice
    assign cmd_slice[g] = mem_cmd_i[g*msg_width_p +: msg_width_p];
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++)
      eligible[i] = mem_cmd_v_i[i] && (credit[i] < credit_w_lp'(max_outstanding_p));
  end

  // Scan downward so the candidate closest to rr_r is the one left standing.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      cand = {1'b0, rr_r} + idx_w_lp'(k);
      if (cand >= idx_w_lp'(num_req_p))
        cand = cand - idx_w_lp'(num_req_p);
      if (eligible[cand[lg_req_lp-1:0]])
        pick = cand[lg_req_lp-1:0];
    end
  end

  assign fifo_full     = (count == cnt_w_lp'(sid_els_lp));
  assign fifo_nonempty = (count != '0);
  assign head          = sid_mem[rd_ptr];

  always_comb begin
    state_n     = state_r;
    gnt_n       = gnt_r;
    mem_cmd_v_o = 1'b0;
    send_fire   = 1'b0;
    case (state_r)
      e_idle: begin
        if ((|eligible) && !fifo_full) begin
          gnt_n   = pick;
          state_n = e_send;
        end
      end
      e_send: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_yumi_i) begin
          send_fire = 1'b1;
          state_n   = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  assign gnt_oh         = {{(num_req_p-1){1'b0}}, 1'b1} << gnt_r;
  assign resp_oh        = {{(num_req_p-1){1'b0}}, 1'b1} << head;
  assign rr_next        = (gnt_r == lg_req_lp'(num_req_p - 1)) ? '0 : gnt_r + lg_req_lp'(1);
  assign mem_cmd_o      = cmd_slice[gnt_r];
  assign mem_cmd_yumi_o = send_fire ? gnt_oh : '0;

  // Response path is purely combinational; the FIFO head names the owner.
  assign mem_resp_o       = mem_resp_i;
  assign mem_resp_v_o     = (mem_resp_v_i && fifo_nonempty) ? resp_oh : '0;
  assign mem_resp_ready_o = fifo_nonempty && mem_resp_ready_i[head];
  assign resp_fire        = mem_resp_v_i && mem_resp_ready_o;

  assign inc_oh = send_fire ? gnt_oh : '0;
  assign dec_oh = resp_fire ? resp_oh : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      gnt_r   <= '0;
      rr_r    <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < num_req_p; i++) credit[i] <= '0;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      if (send_fire) begin
        rr_r   <= rr_next;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (resp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({send_fire, resp_fire})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
      // A same-cycle increment and decrement on one requester cancel out.
      for (int i = 0; i < num_req_p; i++) begin
        case ({inc_oh[i], dec_oh[i]})
          2'b10: if (credit[i] != credit_w_lp'(max_outstanding_p))
                   credit[i] <= credit[i] + credit_w_lp'(1);
          2'b01: if (credit[i] != '0)
                   credit[i] <= credit[i] - credit_w_lp'(1);
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (send_fire) sid_mem[wr_ptr] <= gnt_r;
  end

endmodule

// File: tb/tb_bp_cce_mem_arbiter.sv
// Directed bench for bp_cce_mem_arbiter: expected grants and response owners are queued
// as stimulus is driven and consumed when the DUT issues commands or steers responses.
module tb_bp_cce_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_data [2];
  logic [63:0] mem_cmd_i;
  logic [1:0]  mem_cmd_v_i, mem_cmd_yumi_o, mem_resp_v_o, mem_resp_ready_i;
  logic [31:0] mem_cmd_o, mem_resp_i, mem_resp_o;
  logic        mem_cmd_v_o, mem_cmd_yumi_i, mem_resp_v_i, mem_resp_ready_o;

  int checks, errors;
  int exp_gnt_q[$];
  int src_q[$];
  int outstanding [2];

  always #5 clk = ~clk;

  assign mem_cmd_i = {cmd_data[1], cmd_data[0]};

  bp_cce_mem_arbiter #(.num_req_p(2), .msg_width_p(32), .max_outstanding_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i)
  );

  function automatic logic [1:0] onehot(input int i);
    logic [1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd_v, input logic yumi,
                               input logic resp_v, input logic [1:0] resp_ready);
    mem_cmd_v_i      = cmd_v;
    mem_cmd_yumi_i   = yumi;
    mem_resp_v_i     = resp_v;
    mem_resp_ready_i = resp_ready;
  endtask

  task automatic doReset(input logic resp_v);
    reset_n = 1'b0;
    applyStimulus(2'b00, 1'b0, resp_v, 2'b11);
    tick();
    reset_n = 1'b1;
    exp_gnt_q.delete();
    src_q.delete();
    outstanding[0] = 0;
    outstanding[1] = 0;
  endtask

  // Waits (bounded) for a command, checks it against the next expected grant, then consumes it.
  task automatic serveCmd();
    int n = 0;
    int g;
    while (mem_cmd_v_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checkOutput("cmd_timeout", 32'(mem_cmd_v_o), 32'd1);
      return;
    end
    if (exp_gnt_q.size() == 0) begin
      checkOutput("cmd_unexpected", 32'(mem_cmd_v_o), 32'd0);
      return;
    end
    g = exp_gnt_q.pop_front();
    checkOutput("cmd_data", mem_cmd_o, cmd_data[g]);
    mem_cmd_yumi_i = 1'b1;
    #1;
    checkOutput("cmd_yumi", 32'(mem_cmd_yumi_o), 32'(onehot(g)));
    src_q.push_back(g);
    outstanding[g]++;
    tick();
    mem_cmd_yumi_i = 1'b0;
  endtask

  task automatic serveResp(input logic [31:0] data);
    int s;
    mem_resp_i   = data;
    mem_resp_v_i = 1'b1;
    #1;
    if (src_q.size() == 0) begin
      checkOutput("resp_unexpected", 32'(mem_resp_ready_o), 32'd0);
    end else begin
      s = src_q.pop_front();
      checkOutput("resp_v", 32'(mem_resp_v_o), 32'(onehot(s)));
      checkOutput("resp_ready", 32'(mem_resp_ready_o), 32'd1);
      checkOutput("resp_data", mem_resp_o, data);
      outstanding[s]--;
    end
    tick();
    mem_resp_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cmd_data[0] = 32'hC0DE_0000;
    cmd_data[1] = 32'hC0DE_1111;
    mem_resp_i  = '0;
    outstanding[0] = 0;
    outstanding[1] = 0;

    // Reset held three cycles with every input active.
    reset_n = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b1, 2'b11);
    repeat (3) tick();
    checkOutput("rst_cmd_v", 32'(mem_cmd_v_o), 32'd0);
    checkOutput("rst_cmd_yumi", 32'(mem_cmd_yumi_o), 32'd0);
    checkOutput("rst_resp_v", 32'(mem_resp_v_o), 32'd0);
    checkOutput("rst_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
    reset_n = 1'b1;
    tick();
    checkOutput("idle_cmd_v", 32'(mem_cmd_v_o), 32'd0);

    applyStimulus(2'b01, 1'b0, 1'b0, 2'b11);
    exp_gnt_q.push_back(0);
    #1;
    checkOutput("lat_same_cycle", 32'(mem_cmd_v_o), 32'd0);
    tick();
    checkOutput("lat_next_cycle", 32'(mem_cmd_v_o), 32'd1);
    serveCmd();
    mem_cmd_v_i = 2'b00;
    serveResp(32'h5555_0000);

    // Both requesters continuously valid: grants alternate starting from 0.
    doReset(1'b0);
    mem_cmd_v_i = 2'b11;
    for (int i = 0; i < 4; i++) exp_gnt_q.push_back(i % 2);
    for (int i = 0; i < 4; i++) serveCmd();
    mem_cmd_v_i = 2'b00;
    for (int i = 0; i < 4; i++) serveResp(32'hA000_0000 + 32'(i));

    // Requester 0 alone saturates its four credits.
    mem_cmd_v_i = 2'b01;
    for (int i = 0; i < 4; i++) exp_gnt_q.push_back(0);
    for (int i = 0; i < 4; i++) serveCmd();
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("cap_hold", 32'(mem_cmd_v_o), 32'd0);
    end
    checkOutput("credit0_full", 32'(dut.credit[0]), 32'(outstanding[0]));
    serveResp(32'hB000_0000);
    checkOutput("free_same_cycle", 32'(mem_cmd_v_o), 32'd0);
    checkOutput("credit0_freed", 32'(dut.credit[0]), 32'd3);
    exp_gnt_q.push_back(0);
    tick();
    checkOutput("free_next_cycle", 32'(mem_cmd_v_o), 32'd1);
    serveCmd();
    mem_cmd_v_i = 2'b00;
    for (int i = 0; i < 4; i++) serveResp(32'hB100_0000 + 32'(i));

    // Memory stalls yumi; requester 1 arriving late must not preempt.
    mem_cmd_v_i = 2'b01;
    exp_gnt_q.push_back(0);
    tick();
    checkOutput("stall_cmd_v", 32'(mem_cmd_v_o), 32'd1);
    mem_cmd_v_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_data", mem_cmd_o, cmd_data[0]);
      checkOutput("stall_v", 32'(mem_cmd_v_o), 32'd1);
    end
    exp_gnt_q.push_back(1);
    serveCmd();
    mem_cmd_v_i = 2'b10;
    serveCmd();
    mem_cmd_v_i = 2'b00;

    // Response for requester 1 blocked by its ready, then accepted alongside a new command to 1.
    serveResp(32'hC000_0000);
    mem_resp_i = 32'hC111_0000;
    applyStimulus(2'b10, 1'b0, 1'b1, 2'b01);
    exp_gnt_q.push_back(1);
    #1;
    checkOutput("blk_ready", 32'(mem_resp_ready_o), 32'd0);
    checkOutput("blk_resp_v", 32'(mem_resp_v_o), 32'b10);
    tick();
    checkOutput("blk_ready_hold", 32'(mem_resp_ready_o), 32'd0);
    tick();
    checkOutput("blk_ready_hold2", 32'(mem_resp_ready_o), 32'd0);
    checkOutput("blk_cmd_v", 32'(mem_cmd_v_o), 32'd1);
    mem_resp_ready_i = 2'b11;
    mem_cmd_yumi_i   = 1'b1;
    #1;
    checkOutput("both_ready", 32'(mem_resp_ready_o), 32'd1);
    checkOutput("both_resp_v", 32'(mem_resp_v_o), 32'(onehot(src_q[0])));
    checkOutput("both_cmd_data", mem_cmd_o, cmd_data[exp_gnt_q[0]]);
    checkOutput("both_cmd_yumi", 32'(mem_cmd_yumi_o), 32'(onehot(exp_gnt_q[0])));
    outstanding[src_q.pop_front()]--;
    src_q.push_back(exp_gnt_q[0]);
    outstanding[exp_gnt_q.pop_front()]++;
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11);
    checkOutput("credit1_same", 32'(dut.credit[1]), 32'(outstanding[1]));
    serveResp(32'hC222_0000);
    mem_resp_v_i = 1'b1;
    #1;
    checkOutput("empty_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    checkOutput("empty_resp_v", 32'(mem_resp_v_o), 32'd0);
    mem_resp_v_i = 1'b0;

    // Reset with three commands outstanding discards all tracking.
    mem_cmd_v_i = 2'b01;
    for (int i = 0; i < 3; i++) exp_gnt_q.push_back(0);
    for (int i = 0; i < 3; i++) serveCmd();
    mem_cmd_v_i = 2'b00;
    checkOutput("credit0_three", 32'(dut.credit[0]), 32'(outstanding[0]));
    doReset(1'b1);
    #1;
    checkOutput("post_rst_credit0", 32'(dut.credit[0]), 32'd0);
    checkOutput("post_rst_stale_ready", 32'(mem_resp_ready_o), 32'd0);
    checkOutput("post_rst_stale_v", 32'(mem_resp_v_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stale_hold", 32'(mem_resp_ready_o), 32'd0);
    end
    mem_resp_v_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cce_mem_arbiter.md
# bp_cce_mem_arbiter

Shares one memory command/response port between `num_req_p` buffered CCEs. It round-robin arbitrates their outbound mem commands onto a single memory channel. It records the source of each issued command in an in-order source-ID FIFO and steers each returning memory response to the CCE that issued it. It also enforces a per-CCE cap on outstanding memory transactions, so no CCE can exceed the depth of its own mem response buffer.

## Interface
- `num_req_p`, default 2: number of CCE requesters; must be ≥2.
- `msg_width_p`, default 128: width of one mem message; payload is opaque to this block.
- `max_outstanding_p`, default 4: per-requester outstanding-command cap; set to the requester's mem response FIFO depth.
- `lg_req_lp`, derived: `clog2(num_req_p)`.
- `sid_els_lp`, derived: `num_req_p*max_outstanding_p`, the source-ID FIFO depth.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, synchronous, active-low. The block has one clock; reset is synchronous and active-low.
- `mem_cmd_i` in `num_req_p*msg_width_p`: requester commands; slice i belongs to requester i.
- `mem_cmd_v_i` in `num_req_p`: requester command valid.
- `mem_cmd_yumi_o` out `num_req_p`: command consumed (valid->yumi).
- `mem_cmd_o` out `msg_width_p`: command to memory.
- `mem_cmd_v_o` out 1: command valid to memory.
- `mem_cmd_yumi_i` in 1: memory consumed the command.
- `mem_resp_i` in `msg_width_p`: response from memory.
- `mem_resp_v_i` in 1: response valid.
- `mem_resp_ready_o` out 1: arbiter can accept the response (ready&valid).
- `mem_resp_o` out `msg_width_p`: response broadcast to all requesters.
- `mem_resp_v_o` out `num_req_p`: one-hot response valid.
- `mem_resp_ready_i` in `num_req_p`: requester response-buffer ready.

## Operation
- Memory returns responses in command-issue order. The arbiter holds no per-message tags.
- State: `credit[i]` (width `clog2(max_outstanding_p+1)`), round-robin pointer `rr_r`, registered grant `gnt_r`, FSM state, and source-ID FIFO (`sid_els_lp` × `lg_req_lp`).
- Requester i is eligible when `mem_cmd_v_i[i]` is set and `credit[i] < max_outstanding_p`.
- FSM e_idle:
  - If any requester is eligible and the SID FIFO is not full, latch `gnt_r` = the first eligible index at or after `rr_r` (wrapping modulo `num_req_p`). Go to e_send.
  - Otherwise stay in e_idle.
- FSM e_send:
  - `mem_cmd_v_o`=1 and `mem_cmd_o`=slice `gnt_r`.
  - When `mem_cmd_yumi_i`=1 in the same cycle:
    - `mem_cmd_yumi_o[gnt_r]`=1,
    - push `gnt_r` into the SID FIFO,
    - `credit[gnt_r]`+1,
    - `rr_r`=`gnt_r`+1, wrapping `num_req_p-1`→0,
    - go to e_idle.
  - Otherwise hold `gnt_r` and the data stable.
- Requesters must hold `mem_cmd_v_i`/data stable until yumi. Deasserting the granted valid in e_send is illegal.
- Response path:
  - `d` = SID FIFO head.
  - `mem_resp_o`=`mem_resp_i`.
  - `mem_resp_v_o` = one-hot(d) & {`mem_resp_v_i` & fifo_nonempty}.
  - `mem_resp_ready_o` = fifo_nonempty & `mem_resp_ready_i[d]`.
  - On `mem_resp_v_i & mem_resp_ready_o`: pop the FIFO and `credit[d]`−1.
- A response arriving with the SID FIFO empty is never accepted (`mem_resp_ready_o`=0). This is a protocol error; the bench flags it.
- If one cycle both increments and decrements the same credit, it is unchanged. Increments and decrements on different requesters apply independently.
- A simultaneous FIFO push and pop is legal at any occupancy, including full (pop-before-push) and empty (push only; the head is not valid until the next cycle).
- Credits never exceed `max_outstanding_p` and never underflow.

## Timing
- Reset (`reset_n_i`=0 at a clock edge):
  - FSM=e_idle, `rr_r`=0, `gnt_r`=0, all credits 0, SID FIFO empty.
  - Outputs: `mem_cmd_v_o`=0, `mem_cmd_yumi_o`=0, `mem_resp_v_o`=0, `mem_resp_ready_o`=0.
  - Reset mid-transaction discards all tracking. Responses still in flight after reset are not accepted.
- Command latency: requester valid in cycle N (e_idle) → `mem_cmd_v_o` in N+1 → yumi no earlier than N+1.
- Peak command throughput is one command per 2 cycles, because e_idle is a bubble after every send.
- `mem_cmd_v_o` does not depend combinationally on `mem_cmd_yumi_i`. `mem_cmd_yumi_o` is combinational from `mem_cmd_yumi_i`.
- The response path is fully combinational, with zero latency and no buffering.
- A credit freed by a response in cycle N is visible to eligibility in cycle N+1.

## Test plan
- Reset hold 3 cycles, with all inputs active → all outputs 0; release → `mem_cmd_v_o` first asserts 1 cycle after e_idle sees a valid.
- Both requesters continuously valid, memory yumis every e_send cycle → grants alternate 0,1,0,1. Response order 0,1,0,1 steers `mem_resp_v_o`=01,10,01,10.
- Requester 0 alone with `max_outstanding_p`=4 and no responses → exactly 4 commands issued, then `mem_cmd_v_o` stays 0. One response → `credit[0]`=3 and a fifth command issues.
- Memory withholds yumi for 5 cycles in e_send → `mem_cmd_o` and `gnt_r` are stable, and a newly valid requester 1 does not preempt.
- Response to requester 1 with `mem_resp_ready_i[1]`=0 → `mem_resp_ready_o`=0 and the FIFO is not popped. When ready goes to 1, it is accepted in that cycle. A same-cycle command to requester 1 plus a response leaves `credit[1]` unchanged.
- Reset asserted with 3 outstanding commands → credits 0 and FIFO empty. A stale `mem_resp_v_i` is not accepted (`mem_resp_ready_o`=0).
